sd_drive_arbiter: RTL and testbench

Shares the single host block-I/O channel (sd_lba / sd_rd / sd_wr / sd_ack) between up to four SPI SD-card emulators running on clk_sys. Each drive raises a level request, and the block grants drives one at a time in round-robin order. It forwards the granted drive's LBA and direction to the host, reports the drive index, and returns sd_ack only to the granted drive. It sits between the per-drive card instances and the HPS I/O bridge.

---
 rtl/sd_drive_arbiter_pkg.sv | 39 +++
 rtl/sd_drive_arbiter_if.sv | 47 ++++
 rtl/sd_drive_arbiter_rr_pick.sv | 33 +++
 rtl/sd_drive_arbiter.sv | 156 +++++++++++++++
 tb/tb_sd_drive_arbiter.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/sd_drive_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : sd_arb_pkg                                                   |
// | Description : Shared state encoding and round-robin scan helper for the    |
// |               SD drive arbiter.                                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package sd_arb_pkg;

    localparam int c_MAX_DRV = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        REL  = 2'd3
    } arb_state_t;

    // Returns the first requester after ptr (wrapping modulo ndrv), or -1 if none.
    // Scanning from the farthest offset down leaves the nearest hit as the result.
    function automatic int next_rr(input int ptr, input logic [c_MAX_DRV-1:0] req, input int ndrv);
        int pick;
        int j;
        pick = -1;
        for (int k = c_MAX_DRV; k >= 1; k--) begin
            if (k <= ndrv) begin
                j = (ptr + k) % ndrv;
                if (req[j[1:0]]) begin
                    pick = j;
                end
            end
        end
        return pick;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sd_drive_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | Module      : sd_drive_arbiter_if                                          |
// | Description : Per-drive request bundle plus shared host block-I/O channel. |
// |               err exists only when SD_ARB_TIMEOUT_EN is defined.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

interface sd_drive_arbiter_if #(
    parameter int NDRV   = 2,
    parameter int DW_SEL = $clog2(NDRV)
);
    logic [32*NDRV-1:0] drv_lba;
    logic [NDRV-1:0]    drv_rd;
    logic [NDRV-1:0]    drv_wr;
    logic [NDRV-1:0]    drv_ack;
    logic [31:0]        sd_lba;
    logic               sd_rd;
    logic               sd_wr;
    logic [DW_SEL-1:0]  sd_drv;
    logic               sd_ack;
    logic               busy;
`ifdef SD_ARB_TIMEOUT_EN
    logic [NDRV-1:0]    err;

    modport slave (
        input  drv_lba, drv_rd, drv_wr, sd_ack,
        output drv_ack, sd_lba, sd_rd, sd_wr, sd_drv, busy, err
    );
    modport master (
        output drv_lba, drv_rd, drv_wr, sd_ack,
        input  drv_ack, sd_lba, sd_rd, sd_wr, sd_drv, busy, err
    );
`else
    modport slave (
        input  drv_lba, drv_rd, drv_wr, sd_ack,
        output drv_ack, sd_lba, sd_rd, sd_wr, sd_drv, busy
    );
    modport master (
        output drv_lba, drv_rd, drv_wr, sd_ack,
        input  drv_ack, sd_lba, sd_rd, sd_wr, sd_drv, busy
    );
`endif

endinterface

`default_nettype wire

// File: rtl/sd_drive_arbiter_rr_pick.sv
// +----------------------------------------------------------------------------+
// | Module      : sd_rr_pick                                                   |
// | Description : Combinational round-robin picker: first requester after ptr. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module sd_rr_pick
    import sd_arb_pkg::*;
#(
    parameter int NDRV   = 2,
    parameter int DW_SEL = $clog2(NDRV)
) (
    input  wire logic [NDRV-1:0]   i_req,
    input  wire logic [DW_SEL-1:0] i_ptr,
    output logic                   o_valid,
    output logic [DW_SEL-1:0]      o_idx
);

    logic [c_MAX_DRV-1:0] w_req_ext;
    int                   w_pick;

    always_comb begin
        w_req_ext             = '0;
        w_req_ext[NDRV-1:0]   = i_req;
        w_pick                = next_rr(int'(i_ptr), w_req_ext, NDRV);
        o_valid               = (w_pick >= 0);
        o_idx                 = o_valid ? DW_SEL'(w_pick) : '0;
    end

endmodule

`default_nettype wire

// File: rtl/sd_drive_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module      : sd_drive_arbiter                                             |
// | Description : Round-robin sharing of the host SD block channel among up to |
// |               four drives. SD_ARB_TIMEOUT_EN adds the REQ abort timer+err. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module sd_drive_arbiter
    import sd_arb_pkg::*;
#(
    parameter int          NDRV    = 2,
    parameter int          DW_SEL  = $clog2(NDRV),
    parameter logic [23:0] TIMEOUT = 24'd16777215
) (
    input wire logic          clk_sys,
    input wire logic          reset,
    sd_drive_arbiter_if.slave bus
);

    arb_state_t        r_state;
    logic [DW_SEL-1:0] r_ptr;
    logic [DW_SEL-1:0] r_drv;
    logic [31:0]       r_lba;
    logic              r_rd;
    logic              r_wr;

    logic              w_valid;
    logic [DW_SEL-1:0] w_pick;
    logic [31:0]       w_lba;
    logic              w_dir_rd;
    logic              w_dir_wr;
    logic              w_timeout;
    logic              w_fwd;

    sd_rr_pick #(
        .NDRV   (NDRV),
        .DW_SEL (DW_SEL)
    ) u_pick (
        .i_req   (bus.drv_rd | bus.drv_wr),
        .i_ptr   (r_ptr),
        .o_valid (w_valid),
        .o_idx   (w_pick)
    );

    // Read wins when a drive raises both directions at once.
    always_comb begin
        w_lba    = '0;
        w_dir_rd = 1'b0;
        w_dir_wr = 1'b0;
        for (int i = 0; i < NDRV; i++) begin
            if (w_pick == DW_SEL'(i)) begin
                w_lba    = bus.drv_lba[32*i +: 32];
                w_dir_rd = bus.drv_rd[i];
                w_dir_wr = bus.drv_wr[i] & ~bus.drv_rd[i];
            end
        end
    end

`ifdef SD_ARB_TIMEOUT_EN
    logic [23:0]     r_cnt;
    logic [NDRV-1:0] r_err;

    assign w_timeout = (r_state == REQ) && !bus.sd_ack && (r_cnt == TIMEOUT - 24'd1);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_cnt <= '0;
            r_err <= '0;
        end else begin
            r_err <= '0;
            if (r_state != REQ) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 24'd1;
            end
            if (w_timeout) begin
                for (int i = 0; i < NDRV; i++) begin
                    if (r_drv == DW_SEL'(i)) begin
                        r_err[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.err = r_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT;
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= DW_SEL'(NDRV - 1);
            r_drv   <= '0;
            r_lba   <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // A host ack still high from a previous transfer blocks new grants.
                    if (!bus.sd_ack && w_valid) begin
                        r_lba   <= w_lba;
                        r_drv   <= w_pick;
                        r_ptr   <= w_pick;
                        r_rd    <= w_dir_rd;
                        r_wr    <= w_dir_wr;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (bus.sd_ack) begin
                        r_rd    <= 1'b0;
                        r_wr    <= 1'b0;
                        r_state <= XFER;
                    end else if (w_timeout) begin
                        r_rd    <= 1'b0;
                        r_wr    <= 1'b0;
                        r_state <= REL;
                    end
                end
                XFER: begin
                    if (!bus.sd_ack) begin
                        r_state <= REL;
                    end
                end
                REL: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Ack is only forwarded while the grant owns the channel, never in IDLE/REL.
    assign w_fwd = (r_state == REQ) || (r_state == XFER);

    for (genvar i = 0; i < NDRV; i++) begin : g_ack
        assign bus.drv_ack[i] = bus.sd_ack & w_fwd & (r_drv == DW_SEL'(i));
    end

    assign bus.sd_lba = r_lba;
    assign bus.sd_rd  = r_rd;
    assign bus.sd_wr  = r_wr;
    assign bus.sd_drv = r_drv;
    assign bus.busy   = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sd_drive_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_sd_drive_arbiter                                          |
// | Description : Directed self-checking bench for sd_drive_arbiter, NDRV=4.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sd_drive_arbiter;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    int   total   = 0;
    int   bad     = 0;

    always #5 clk_sys = ~clk_sys;

    sd_drive_arbiter_if #(.NDRV(4), .DW_SEL(2)) bus ();

    sd_drive_arbiter #(
        .NDRV    (4),
        .DW_SEL  (2),
        .TIMEOUT (24'd16)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(bus.sd_rd || bus.sd_wr) && n < 20);
        chk("grant_seen", 32'(bus.sd_rd | bus.sd_wr), 32'd1);
    endtask

    // Host ack held for len cycles; returns with sd_ack low, not yet clocked.
    task automatic ack_cycle(input int g, input int len);
        bus.sd_ack = 1'b1;
        #1;
        chk("drv_ack_rise", 32'(bus.drv_ack), 32'(4'b0001 << g));
        tick();
        chk("req_drop", 32'(bus.sd_rd | bus.sd_wr), 32'd0);
        repeat (len - 1) tick();
        bus.sd_ack = 1'b0;
    endtask

    initial begin
        int n;
        bus.drv_lba = '0;
        bus.drv_rd  = '0;
        bus.drv_wr  = '0;
        bus.sd_ack  = 1'b0;

        // Reset state
        do_reset();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_rd", 32'(bus.sd_rd), 32'd0);
        chk("rst_wr", 32'(bus.sd_wr), 32'd0);
        chk("rst_lba", bus.sd_lba, 32'd0);
        chk("rst_drv", 32'(bus.sd_drv), 32'd0);
        chk("rst_ack", 32'(bus.drv_ack), 32'd0);

        // Single read on drive 1, 10-cycle host ack
        bus.drv_lba[63:32] = 32'h0000_1234;
        bus.drv_rd[1]      = 1'b1;
        tick();
        chk("sr_rd", 32'(bus.sd_rd), 32'd1);
        chk("sr_wr", 32'(bus.sd_wr), 32'd0);
        chk("sr_drv", 32'(bus.sd_drv), 32'd1);
        chk("sr_lba", bus.sd_lba, 32'h0000_1234);
        chk("sr_busy", 32'(bus.busy), 32'd1);
        bus.sd_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("sr_drv_ack", 32'(bus.drv_ack), 32'h2);
            tick();
            if (i == 0) begin
                chk("sr_rd_drop", 32'(bus.sd_rd), 32'd0);
                bus.drv_rd[1] = 1'b0;
            end
        end
        bus.sd_ack = 1'b0;
        #1;
        chk("sr_ack_fall", 32'(bus.drv_ack), 32'd0);
        tick();
        chk("sr_rel_busy", 32'(bus.busy), 32'd1);
        tick();
        chk("sr_idle_busy", 32'(bus.busy), 32'd0);

        // Fairness: all four drives request continuously
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.drv_lba[32*i +: 32] = 32'h100 + 32'(i);
        end
        bus.drv_rd = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_grant(n);
            if (k > 0) chk("fair_gap", 32'(n), 32'd3);
            chk("fair_drv", 32'(bus.sd_drv), 32'(k % 4));
            chk("fair_lba", bus.sd_lba, 32'h100 + 32'(k % 4));
            ack_cycle(k % 4, 3);
        end
        bus.drv_rd = '0;
        tick();
        tick();

        // Read/write conflict on drive 2
        do_reset();
        bus.drv_rd[2] = 1'b1;
        bus.drv_wr[2] = 1'b1;
        wait_grant(n);
        chk("rw_drv", 32'(bus.sd_drv), 32'd2);
        chk("rw_rd", 32'(bus.sd_rd), 32'd1);
        chk("rw_wr", 32'(bus.sd_wr), 32'd0);
        ack_cycle(2, 2);
        bus.drv_rd = '0;
        bus.drv_wr = '0;
        tick();
        tick();
        bus.sd_ack = 1'b1;
        #1;
        chk("idle_ack_blocked", 32'(bus.drv_ack), 32'd0);
        bus.sd_ack = 1'b0;

        // Stale ack held across reset
        bus.sd_ack    = 1'b1;
        bus.drv_wr[0] = 1'b1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stale_wr", 32'(bus.sd_wr), 32'd0);
            chk("stale_busy", 32'(bus.busy), 32'd0);
        end
        bus.sd_ack = 1'b0;
        tick();
        chk("stale_wr_go", 32'(bus.sd_wr), 32'd1);
        chk("stale_rd", 32'(bus.sd_rd), 32'd0);
        chk("stale_drv", 32'(bus.sd_drv), 32'd0);
        ack_cycle(0, 2);
        bus.drv_wr = '0;
        tick();
        tick();

        // LBA stability while in XFER
        bus.drv_lba[31:0] = 32'hAAAA_0000;
        bus.drv_rd[0]     = 1'b1;
        wait_grant(n);
        chk("lba_grant", bus.sd_lba, 32'hAAAA_0000);
        bus.sd_ack = 1'b1;
        tick();
        bus.drv_rd[0]     = 1'b0;
        bus.drv_lba[31:0] = 32'h0000_5555;
        tick();
        chk("lba_xfer", bus.sd_lba, 32'hAAAA_0000);
        chk("lba_drv_ack", 32'(bus.drv_ack), 32'h1);
        bus.sd_ack = 1'b0;
        tick();
        chk("lba_rel", bus.sd_lba, 32'hAAAA_0000);
        chk("lba_rel_busy", 32'(bus.busy), 32'd1);
        tick();
        chk("lba_idle_busy", 32'(bus.busy), 32'd0);

`ifdef SD_ARB_TIMEOUT_EN
        // Timeout abort on drive 1, then drive 2 gets its turn
        do_reset();
        bus.drv_rd[1] = 1'b1;
        bus.drv_rd[2] = 1'b1;
        wait_grant(n);
        chk("to_drv", 32'(bus.sd_drv), 32'd1);
        chk("to_err_idle", 32'(bus.err), 32'd0);
        n = 1;
        while (bus.sd_rd && n < 40) begin
            tick();
            if (bus.sd_rd) n++;
        end
        chk("to_len", 32'(n), 32'd16);
        chk("to_err_pulse", 32'(bus.err), 32'h2);
        tick();
        chk("to_err_clear", 32'(bus.err), 32'd0);
        tick();
        chk("to_next_drv", 32'(bus.sd_drv), 32'd2);
        chk("to_next_rd", 32'(bus.sd_rd), 32'd1);
        bus.drv_rd = '0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
